// File: rtl/vga_frame_scanner.sv
// Display-side scanner: 640x480@60 raster timing that walks the video RAM read port in raster order
// and registers each returned pixel onto the VGA pins, with the syncs aligned to the same pixel.
module vga_frame_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 24
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iEnable,
    input  logic [2:0]        iPixelData,
    output logic [ADDR_W-1:0] oReadAddress,
    output logic              oVGA_R,
    output logic              oVGA_G,
    output logic              oVGA_B,
    output logic              oHSync,
    output logic              oVSync,
    output logic              oVBlank,
    output logic              oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0]     divider;
    logic [HW-1:0]     hcount;
    logic [HW-1:0]     h_next;
    logic [VW-1:0]     vcount;
    logic [VW-1:0]     v_next;
    logic [ADDR_W-1:0] address;
    logic [2:0]        pixel_hold;
    logic [2:0]        rgb;
    logic              tick;
    logic              active_now;
    logic              active_next;
    logic              frame_wrap;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              hsync_q;
    logic              vsync_q;
    logic              vblank_q;
    logic              frame_start_q;

    always_comb begin
        tick   = (divider == DIV_LAST);
        h_next = hcount + 1'b1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
        active_now  = (hcount < H_VIS) && (vcount < V_VIS);
        active_next = (h_next < H_VIS) && (v_next < V_VIS);
        frame_wrap  = (hcount == H_LAST) && (vcount == V_LAST);
        hsync_raw   = ~((hcount >= HS_START) && (hcount <= HS_END));
        vsync_raw   = ~((vcount >= VS_START) && (vcount <= VS_END));
    end

    // Everything visible is registered on the tick that ends a pixel, so RGB and syncs share one pixel of lag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            divider       <= '0;
            hcount        <= '0;
            vcount        <= '0;
            address       <= '0;
            pixel_hold    <= '0;
            rgb           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            divider       <= tick ? '0 : divider + 1'b1;
            frame_start_q <= tick && frame_wrap;
            // Divider is 0 exactly one clock after the address moved, when the RAM data for it is valid.
            if (divider == '0) begin
                pixel_hold <= iPixelData;
            end
            if (tick) begin
                hcount <= h_next;
                vcount <= v_next;
                if (frame_wrap) begin
                    address <= '0;
                end else if (active_next) begin
                    address <= address + 1'b1;
                end
                rgb      <= (active_now && iEnable) ? pixel_hold : 3'b000;
                hsync_q  <= hsync_raw;
                vsync_q  <= vsync_raw;
                vblank_q <= (vcount >= V_VIS);
            end
        end
    end

    assign oReadAddress = address;
    assign oVGA_R       = rgb[2];
    assign oVGA_G       = rgb[1];
    assign oVGA_B       = rgb[0];
    assign oHSync       = hsync_q;
    assign oVSync       = vsync_q;
    assign oVBlank      = vblank_q;
    assign oFrameStart  = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner, run on a shrunken raster (30x19 pixels, 16x12 visible)
// so whole frames fit in a short run; expected clock counts are derived from those sizes.
module tb_vga_frame_scanner;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int CLK_DIV  = 2;
    localparam int ADDR_W   = 24;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [2:0]        pixel_data;
    logic [ADDR_W-1:0] read_address;
    logic              vga_r;
    logic              vga_g;
    logic              vga_b;
    logic              hsync;
    logic              vsync;
    logic              vblank;
    logic              frame_start;
    logic [2:0]        rgb;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_frame_scanner #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)
    ) dut (
        .Clock(clk),
        .Reset(reset),
        .iEnable(enable),
        .iPixelData(pixel_data),
        .oReadAddress(read_address),
        .oVGA_R(vga_r),
        .oVGA_G(vga_g),
        .oVGA_B(vga_b),
        .oHSync(hsync),
        .oVSync(vsync),
        .oVBlank(vblank),
        .oFrameStart(frame_start)
    );

    // Video RAM stand-in: each location holds the low three bits of its own address.
    always_comb pixel_data = read_address[2:0];
    assign rgb = {vga_r, vga_g, vga_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Leaves the bench 1 time unit after the third reset edge with reset released ("edge 0").
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({hsync, vsync} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL reset_syncs: got %b expected 11", {hsync, vsync});
        end
        tests_run++;
        if (rgb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_rgb: got %b expected 000", rgb);
        end
        tests_run++;
        if (read_address !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr: got %0d expected 0", read_address);
        end
        tests_run++;
        if ({vblank, frame_start} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_vblank_fs: got %b expected 00", {vblank, frame_start});
        end
        reset = 1'b0;
        step(1);
        tests_run++;
        if (read_address !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL first_clk_addr: got %0d expected 0", read_address);
        end
        step(1);
        tests_run++;
        if (read_address !== 24'd1) begin
            tests_failed++;
            $display("[TB] FAIL first_tick_addr: got %0d expected 1", read_address);
        end
    endtask

    // hsync falls when pixel 20 is shown (edge 2*20+2), low 6 pixels = 12 clocks, line = 60 clocks.
    task automatic test_line();
        int   fall1;
        int   fall2;
        int   rise1;
        int   vs_low;
        logic prev;
        fall1  = -1;
        fall2  = -1;
        rise1  = -1;
        vs_low = 0;
        prev   = 1'b1;
        do_reset();
        for (int n = 1; n <= 130; n++) begin
            step(1);
            if (prev && !hsync) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prev && hsync && rise1 < 0) rise1 = n;
            if (!vsync) vs_low++;
            prev = hsync;
        end
        tests_run++;
        if (fall1 !== 42) begin
            tests_failed++;
            $display("[TB] FAIL hsync_fall: got edge %0d expected 42", fall1);
        end
        tests_run++;
        if (rise1 - fall1 !== 12) begin
            tests_failed++;
            $display("[TB] FAIL hsync_width: got %0d clks expected 12", rise1 - fall1);
        end
        tests_run++;
        if (fall2 - fall1 !== 60) begin
            tests_failed++;
            $display("[TB] FAIL line_period: got %0d clks expected 60", fall2 - fall1);
        end
        tests_run++;
        if (vs_low !== 0) begin
            tests_failed++;
            $display("[TB] FAIL vsync_first_line: got %0d low clks expected 0", vs_low);
        end
    endtask

    // Frame = 30*19 pixels = 1140 clocks; vsync covers lines 14..15, vblank lines 12..18.
    task automatic test_frame();
        int   vs_fall;
        int   vs_rise;
        int   vb_rise;
        int   vb_fall;
        int   fs_first;
        int   fs_last;
        int   fs_count;
        int   max_addr;
        logic prev_vs;
        logic prev_vb;
        vs_fall  = -1;
        vs_rise  = -1;
        vb_rise  = -1;
        vb_fall  = -1;
        fs_first = -1;
        fs_last  = -1;
        fs_count = 0;
        max_addr = 0;
        prev_vs  = 1'b1;
        prev_vb  = 1'b0;
        do_reset();
        for (int n = 1; n <= 2300; n++) begin
            step(1);
            if (prev_vs && !vsync && vs_fall < 0) vs_fall = n;
            if (!prev_vs && vsync && vs_rise < 0) vs_rise = n;
            if (!prev_vb && vblank && vb_rise < 0) vb_rise = n;
            if (prev_vb && !vblank && vb_fall < 0) vb_fall = n;
            if (frame_start) begin
                fs_count++;
                if (fs_first < 0) fs_first = n;
                fs_last = n;
            end
            if (int'(read_address) > max_addr) max_addr = int'(read_address);
            prev_vs = vsync;
            prev_vb = vblank;
        end
        tests_run++;
        if (vs_fall !== 842) begin
            tests_failed++;
            $display("[TB] FAIL vsync_fall: got edge %0d expected 842", vs_fall);
        end
        tests_run++;
        if (vs_rise - vs_fall !== 120) begin
            tests_failed++;
            $display("[TB] FAIL vsync_width: got %0d clks expected 120", vs_rise - vs_fall);
        end
        tests_run++;
        if (fs_first !== 1140) begin
            tests_failed++;
            $display("[TB] FAIL frame_start_first: got edge %0d expected 1140", fs_first);
        end
        tests_run++;
        if (fs_count !== 2) begin
            tests_failed++;
            $display("[TB] FAIL frame_start_count: got %0d expected 2", fs_count);
        end
        tests_run++;
        if (fs_last - fs_first !== 1140) begin
            tests_failed++;
            $display("[TB] FAIL frame_period: got %0d clks expected 1140", fs_last - fs_first);
        end
        tests_run++;
        if (vb_rise !== 722) begin
            tests_failed++;
            $display("[TB] FAIL vblank_rise: got edge %0d expected 722", vb_rise);
        end
        tests_run++;
        if (vb_fall !== 1142) begin
            tests_failed++;
            $display("[TB] FAIL vblank_fall: got edge %0d expected 1142", vb_fall);
        end
        tests_run++;
        if (max_addr !== 191) begin
            tests_failed++;
            $display("[TB] FAIL max_addr: got %0d expected 191", max_addr);
        end
    endtask

    // Pixel k is addressed during edges 2k..2k+1 and shown on the pins after edge 2k+2.
    task automatic test_pixel_data();
        do_reset();
        for (int n = 1; n <= 1141; n++) begin
            step(1);
            if (n == 12) begin
                tests_run++;
                if (rgb !== 3'b101) begin
                    tests_failed++;
                    $display("[TB] FAIL pixel_5_0: got %b expected 101", rgb);
                end
            end
            if (n == 16) begin
                tests_run++;
                if (rgb !== 3'b111) begin
                    tests_failed++;
                    $display("[TB] FAIL pixel_7_0: got %b expected 111", rgb);
                end
            end
            if (n == 34) begin
                tests_run++;
                if (rgb !== 3'b000) begin
                    tests_failed++;
                    $display("[TB] FAIL hblank_rgb: got %b expected 000", rgb);
                end
            end
            if (n == 40) begin
                tests_run++;
                if (read_address !== 24'd15) begin
                    tests_failed++;
                    $display("[TB] FAIL hblank_addr_hold: got %0d expected 15", read_address);
                end
            end
            if (n == 60) begin
                tests_run++;
                if (read_address !== 24'd16) begin
                    tests_failed++;
                    $display("[TB] FAIL addr_line1: got %0d expected 16", read_address);
                end
            end
            if (n == 64) begin
                tests_run++;
                if (rgb !== 3'b001) begin
                    tests_failed++;
                    $display("[TB] FAIL pixel_1_1: got %b expected 001", rgb);
                end
            end
            if (n == 66) begin
                tests_run++;
                if (rgb !== 3'b010) begin
                    tests_failed++;
                    $display("[TB] FAIL pixel_2_1: got %b expected 010", rgb);
                end
            end
            if (n == 690 || n == 800) begin
                tests_run++;
                if (read_address !== 24'd191) begin
                    tests_failed++;
                    $display("[TB] FAIL addr_max_edge%0d: got %0d expected 191", n, read_address);
                end
            end
            if (n == 1140) begin
                tests_run++;
                if (read_address !== 24'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL addr_wrap: got %0d expected 0", read_address);
                end
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        step(10);
        tests_run++;
        if (rgb !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL enable_before: got %b expected 100", rgb);
        end
        enable = 1'b0;
        step(1);
        tests_run++;
        if (rgb !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL enable_not_before_tick: got %b expected 100", rgb);
        end
        step(1);
        tests_run++;
        if (rgb !== 3'b000 || read_address !== 24'd6) begin
            tests_failed++;
            $display("[TB] FAIL enable_off_tick: got rgb %b addr %0d expected 000 addr 6", rgb, read_address);
        end
        step(4);
        tests_run++;
        if (rgb !== 3'b000 || read_address !== 24'd8 || hsync !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL enable_off_run: got rgb %b addr %0d hs %b expected 000 8 1", rgb, read_address, hsync);
        end
        enable = 1'b1;
        step(6);
        tests_run++;
        if (rgb !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL enable_restore: got %b expected 010", rgb);
        end
    endtask

    // Reset while pixel (21,14) is on the pins: hsync, vsync and vblank all away from reset values.
    task automatic test_mid_reset();
        do_reset();
        step(884);
        tests_run++;
        if ({hsync, vsync, vblank} !== 3'b001 || read_address !== 24'd191) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_state: got hs/vs/vb %b addr %0d expected 001 addr 191", {hsync, vsync, vblank}, read_address);
        end
        reset = 1'b1;
        step(1);
        tests_run++;
        if ({hsync, vsync, vblank, frame_start} !== 4'b1100 || rgb !== 3'b000 || read_address !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got hs/vs/vb/fs %b rgb %b addr %0d expected 1100 000 0", {hsync, vsync, vblank, frame_start}, rgb, read_address);
        end
        reset = 1'b0;
        step(1);
        tests_run++;
        if (read_address !== 24'd0) begin
            tests_failed++;
            $display("[TB] FAIL restart_addr0: got %0d expected 0", read_address);
        end
        step(1);
        tests_run++;
        if (read_address !== 24'd1) begin
            tests_failed++;
            $display("[TB] FAIL restart_addr1: got %0d expected 1", read_address);
        end
        step(10);
        tests_run++;
        if (rgb !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL restart_pixel_5: got %b expected 101", rgb);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_pixel_data();
        test_enable();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
